// File: rtl/sys_array_merge.sv
// sys_array_merge: reassembles split systolic tile results into one matrix and streams it out row-major
// Optional macro SYS_MERGE_SAT_EN: saturating accumulate plus sticky sat_flag output port.
module sys_array_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_W_MAX  = 8,
  parameter int OUT_L_MAX  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [15:0]                  OUT_W,
  input  logic [15:0]                  OUT_L,
  input  logic                         hdr_valid,
  output logic                         hdr_ready,
  input  logic [15:0]                  O_W,
  input  logic [15:0]                  O_L,
  input  logic [15:0]                  T_W,
  input  logic [15:0]                  T_L,
  input  logic                         hdr_acc,
  input  logic                         hdr_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         ready,
  output logic                         err
`ifdef SYS_MERGE_SAT_EN
  ,
  output logic                         sat_flag
`endif
);
  localparam int RW = (OUT_W_MAX > 1) ? $clog2(OUT_W_MAX) : 1;
  localparam int CW = (OUT_L_MAX > 1) ? $clog2(OUT_L_MAX) : 1;
  localparam logic [15:0] W_MAX = 16'(OUT_W_MAX);
  localparam logic [15:0] L_MAX = 16'(OUT_L_MAX);

  typedef enum logic [2:0] {IDLE, CLEAR, HDR, LOAD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] out_w_q, out_w_d, out_l_q, out_l_d;
  logic [15:0] ow_q, ow_d, ol_q, ol_d, tw_q, tw_d, tl_q, tl_d;
  logic [15:0] r_q, r_d, c_q, c_d;
  logic        acc_q, acc_d, last_q, last_d, bad_q, bad_d, err_q, err_d;
  logic        clr_en, wr_en, dims_bad, hdr_oob;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic signed [DATA_WIDTH-1:0] mem [OUT_W_MAX][OUT_L_MAX];
  logic signed [DATA_WIDTH-1:0] cur, sum, wr_data;

  assign dims_bad = OUT_W == 16'd0 || OUT_W > W_MAX || OUT_L == 16'd0 || OUT_L > L_MAX;
  assign hdr_oob  = T_W == 16'd0 || T_L == 16'd0 ||
                    ({1'b0, O_W} + {1'b0, T_W}) > {1'b0, out_w_q} ||
                    ({1'b0, O_L} + {1'b0, T_L}) > {1'b0, out_l_q};
  assign wr_row   = RW'(ow_q + r_q);
  assign wr_col   = CW'(ol_q + c_q);
  assign cur      = mem[wr_row][wr_col];
  assign wr_data  = acc_q ? sum : in_data;
  assign out_data = out_valid ? mem[r_q[RW-1:0]][c_q[CW-1:0]] : '0;
  assign err      = err_q;

`ifdef SYS_MERGE_SAT_EN
  logic signed [DATA_WIDTH-1:0] sum_raw;
  logic ovf, sat_q, sat_d;
  assign sum_raw  = cur + in_data;
  assign ovf      = (cur[DATA_WIDTH-1] == in_data[DATA_WIDTH-1]) && (sum_raw[DATA_WIDTH-1] != cur[DATA_WIDTH-1]);
  assign sum      = ovf ? (cur[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}}) : sum_raw;
  assign sat_flag = sat_q;
  // sticky saturation flag, cleared when a job is started
  always_comb sat_d = (state_q == IDLE && start) ? 1'b0 : sat_q | (wr_en & acc_q & ovf);
  // saturation flag register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sat_q <= 1'b0;
    else sat_q <= sat_d;
`else
  assign sum = cur + in_data;
`endif

  // next-state, handshake outputs and counter updates
  always_comb begin
    state_d   = state_q;
    out_w_d   = out_w_q;
    out_l_d   = out_l_q;
    ow_d      = ow_q;
    ol_d      = ol_q;
    tw_d      = tw_q;
    tl_d      = tl_q;
    r_d       = r_q;
    c_d       = c_q;
    acc_d     = acc_q;
    last_d    = last_q;
    bad_d     = bad_q;
    err_d     = err_q;
    clr_en    = 1'b0;
    wr_en     = 1'b0;
    ready     = state_q == IDLE;
    hdr_ready = state_q == HDR;
    in_ready  = state_q == LOAD;
    out_valid = state_q == DRAIN;
    case (state_q)
      IDLE: if (start) begin
        err_d = dims_bad;
        if (!dims_bad) begin
          out_w_d = OUT_W;
          out_l_d = OUT_L;
          r_d     = 16'd0;
          c_d     = 16'd0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        r_d    = r_q + 16'd1;
        if (r_q == out_w_q - 16'd1) begin
          r_d     = 16'd0;
          state_d = HDR;
        end
      end
      HDR: if (hdr_valid) begin
        ow_d    = O_W;
        ol_d    = O_L;
        tw_d    = (T_W == 16'd0) ? 16'd1 : T_W;
        tl_d    = (T_L == 16'd0) ? 16'd1 : T_L;
        acc_d   = hdr_acc;
        last_d  = hdr_last;
        bad_d   = hdr_oob;
        err_d   = err_q | hdr_oob;
        r_d     = 16'd0;
        c_d     = 16'd0;
        state_d = LOAD;
      end
      LOAD: if (in_valid) begin
        wr_en = !bad_q;
        c_d   = c_q + 16'd1;
        if (c_q == tl_q - 16'd1) begin
          c_d = 16'd0;
          r_d = r_q + 16'd1;
          if (r_q == tw_q - 16'd1) begin
            r_d     = 16'd0;
            state_d = last_q ? DRAIN : HDR;
          end
        end
      end
      DRAIN: if (out_ready) begin
        c_d = c_q + 16'd1;
        if (c_q == out_l_q - 16'd1) begin
          c_d = 16'd0;
          r_d = r_q + 16'd1;
          if (r_q == out_w_q - 16'd1) begin
            r_d     = 16'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control registers, abandoned on reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      out_w_q <= 16'd0;
      out_l_q <= 16'd0;
      ow_q    <= 16'd0;
      ol_q    <= 16'd0;
      tw_q    <= 16'd0;
      tl_q    <= 16'd0;
      r_q     <= 16'd0;
      c_q     <= 16'd0;
      acc_q   <= 1'b0;
      last_q  <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_w_q <= out_w_d;
      out_l_q <= out_l_d;
      ow_q    <= ow_d;
      ol_q    <= ol_d;
      tw_q    <= tw_d;
      tl_q    <= tl_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end

  // result buffer: whole-row clear during CLEAR, one element write per LOAD beat, no reset
  always_ff @(posedge clk)
    if (clr_en) for (int k = 0; k < OUT_L_MAX; k++) mem[r_q[RW-1:0]][k] <= '0;
    else if (wr_en) mem[wr_row][wr_col] <= wr_data;
endmodule

// File: tb/tb_sys_array_merge.sv
// tb_sys_array_merge: directed table plus randomized jobs checked against a matrix-level model
module tb_sys_array_merge;
  logic clk = 1'b0;
  logic reset_n, start, hdr_valid, hdr_ready, hdr_acc, hdr_last;
  logic in_valid, in_ready, out_valid, out_ready, ready, err;
  logic [15:0] OUT_W, OUT_L, O_W, O_L, T_W, T_L;
  logic signed [31:0] in_data, out_data;
`ifdef SYS_MERGE_SAT_EN
  logic sat_flag;
`endif

  typedef int iq_t[$];
  typedef struct {
    int w, l, ow, ol, tw, tl;
    bit acc, last;
    int base, step;
    logic [0:15][7:0] exp;
  } tile_t;

  localparam longint SMAX = 64'sh7fffffff;
  localparam longint SMIN = -SMAX - 1;

  int vecs = 0, fails = 0;
  int m[8][8];
  int mw = 0, ml = 0;
  bit m_err = 0;
  tile_t tab[7];

  sys_array_merge dut (
    .clk(clk), .reset_n(reset_n), .start(start), .OUT_W(OUT_W), .OUT_L(OUT_L),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .O_W(O_W), .O_L(O_L), .T_W(T_W), .T_L(T_L),
    .hdr_acc(hdr_acc), .hdr_last(hdr_last), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ready(ready), .err(err)
`ifdef SYS_MERGE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (hdr_ready && in_ready) begin
      fails++;
      $display("FAIL handshake_overlap: hdr_ready=1 in_ready=1 required not both");
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h)", nm, act, act, expv, expv);
    end
  endtask

  function automatic tile_t mk(input int w, l, ow, ol, tw, tl, input bit acc, last,
                               input int base, step, input logic [0:15][7:0] e);
    tile_t t;
    t.w = w; t.l = l; t.ow = ow; t.ol = ol; t.tw = tw; t.tl = tl;
    t.acc = acc; t.last = last; t.base = base; t.step = step; t.exp = e;
    return t;
  endfunction

  function automatic int madd(input int a, b);
    longint s = longint'(a) + longint'(b);
`ifdef SYS_MERGE_SAT_EN
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
`endif
    return int'(s);
  endfunction

  function automatic iq_t model_out();
    iq_t q;
    for (int r = 0; r < mw; r++)
      for (int c = 0; c < ml; c++) q.push_back(m[r][c]);
    return q;
  endfunction

  task automatic do_start(input int w, l);
    start = 1'b1; OUT_W = 16'(w); OUT_L = 16'(l);
    @(negedge clk);
    start = 1'b0;
    m_err = (w < 1 || w > 8 || l < 1 || l > 8);
    if (!m_err) begin
      mw = w; ml = l;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) m[r][c] = 0;
    end
  endtask

  task automatic send_hdr(input int ow, ol, tw, tl, input bit acc, last);
    int n = 0;
    O_W = 16'(ow); O_L = 16'(ol); T_W = 16'(tw); T_L = 16'(tl);
    hdr_acc = acc; hdr_last = last; hdr_valid = 1'b1;
    while (!hdr_ready && n < 200) begin @(negedge clk); n++; end
    chk("hdr_accept", 32'(hdr_ready), 1);
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input int v, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    in_data = v; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("in_accept", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input int ow, ol, tw, tl, input bit acc, last, input iq_t d, input int gapmax);
    bit bad = (ow + tw > mw) || (ol + tl > ml) || tw < 1 || tl < 1;
    send_hdr(ow, ol, tw, tl, acc, last);
    for (int k = 0; k < d.size(); k++) send_beat(d[k], int'($urandom_range(0, gapmax)));
    if (bad) m_err = 1;
    else
      for (int r = 0; r < tw; r++)
        for (int c = 0; c < tl; c++)
          m[ow+r][ol+c] = acc ? madd(m[ow+r][ol+c], d[r*tl+c]) : d[r*tl+c];
  endtask

  task automatic drain(input iq_t eq, input int mode);
    int k = 0, n = 0;
    logic [31:0] held = '0;
    bit stalled = 0;
    while (k < eq.size() && n < 2000) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : ($urandom_range(0, 1) == 1);
      if (out_valid && stalled) chk("out_stable", out_data, held);
      if (out_valid && out_ready) begin
        chk($sformatf("out[%0d]", k), out_data, eq[k]);
        k++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        held = out_data;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("drain_count", k, eq.size());
    chk("drain_idle", 32'(out_valid), 0);
    chk("ready_back", 32'(ready), 1);
  endtask

  initial begin
    iq_t d, q;
    tile_t tq[$];
    reset_n = 1'b0; start = 1'b0; hdr_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    OUT_W = '0; OUT_L = '0; O_W = '0; O_L = '0; T_W = '0; T_L = '0;
    hdr_acc = 1'b0; hdr_last = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_hdr_ready", 32'(hdr_ready), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    @(negedge clk);

    tab[0] = mk(2, 2, 0, 0, 2, 2, 0, 1, 1, 1, {8'd1, 8'd2, 8'd3, 8'd4, 96'd0});
    tab[1] = mk(2, 2, 0, 0, 2, 2, 1, 0, 1, 1, 128'd0);
    tab[2] = mk(2, 2, 0, 0, 2, 2, 1, 1, 10, 10, {8'd11, 8'd22, 8'd33, 8'd44, 96'd0});
    tab[3] = mk(4, 4, 0, 0, 2, 2, 0, 0, 1, 0, 128'd0);
    tab[4] = mk(4, 4, 0, 2, 2, 2, 0, 0, 2, 0, 128'd0);
    tab[5] = mk(4, 4, 2, 0, 2, 2, 0, 0, 3, 0, 128'd0);
    tab[6] = mk(4, 4, 2, 2, 2, 2, 0, 1, 4, 0,
                {8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2,
                 8'd3, 8'd3, 8'd4, 8'd4, 8'd3, 8'd3, 8'd4, 8'd4});
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || tab[i-1].last) begin
        do_start(tab[i].w, tab[i].l);
        chk("start_err_clear", 32'(err), 0);
        chk("start_busy", 32'(ready), 0);
      end else begin
        start = 1'b1; OUT_W = 16'd1; OUT_L = 16'd1;
        @(negedge clk);
        start = 1'b0;
      end
      d.delete();
      for (int k = 0; k < tab[i].tw * tab[i].tl; k++) d.push_back(tab[i].base + tab[i].step * k);
      send_tile(tab[i].ow, tab[i].ol, tab[i].tw, tab[i].tl, tab[i].acc, tab[i].last, d, 0);
      if (tab[i].last) begin
        chk("first_valid_latency", 32'(out_valid), 1);
        q.delete();
        for (int k = 0; k < tab[i].w * tab[i].l; k++) q.push_back(int'(tab[i].exp[k]));
        drain(q, (i == 6) ? 1 : 0);
      end
    end

    do_start(2, 2);
    send_tile(1, 1, 2, 2, 0, 0, '{9, 9, 9, 9}, 0);
    chk("oob_err", 32'(err), 1);
    chk("oob_beats_consumed", 32'(hdr_ready), 1);
    send_tile(0, 0, 2, 2, 0, 1, '{5, 6, 7, 8}, 0);
    drain('{5, 6, 7, 8}, 0);
    chk("err_sticky", 32'(err), 1);
    do_start(0, 2);
    chk("zero_dim_err", 32'(err), 1);
    chk("zero_dim_ready", 32'(ready), 1);
    chk("zero_dim_no_hdr", 32'(hdr_ready), 0);

    do_start(2, 2);
    chk("restart_err_clear", 32'(err), 0);
    send_hdr(0, 0, 2, 2, 0, 1);
    send_beat(1, 0);
    send_beat(2, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(out_valid | in_ready | hdr_ready), 0);
    end
    do_start(2, 2);
    send_tile(0, 0, 2, 2, 0, 1, '{1, 2, 3, 4}, 0);
    drain('{1, 2, 3, 4}, 0);

    for (int j = 0; j < 8; j++) begin
      int w = int'($urandom_range(1, 8));
      int l = int'($urandom_range(1, 8));
      int rs = int'($urandom_range(1, w));
      int cs = int'($urandom_range(1, l));
      do_start(w, l);
      tq.delete();
      for (int bi = 0; bi < 2; bi++)
        for (int bj = 0; bj < 2; bj++) begin
          int r0 = bi ? rs : 0;
          int rh = bi ? w - rs : rs;
          int c0 = bj ? cs : 0;
          int ch = bj ? l - cs : cs;
          if (rh > 0 && ch > 0)
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
              tq.push_back(mk(w, l, r0, c0, rh, ch, $urandom_range(0, 1) == 1, 0, 0, 0, 128'd0));
        end
      tq[tq.size()-1].last = 1;
      foreach (tq[t]) begin
        d.delete();
        for (int k = 0; k < tq[t].tw * tq[t].tl; k++) d.push_back(int'($urandom));
        send_tile(tq[t].ow, tq[t].ol, tq[t].tw, tq[t].tl, tq[t].acc, tq[t].last, d, 2);
      end
      drain(model_out(), 2);
      chk("rand_err", 32'(err), 32'(m_err));
    end

`ifdef SYS_MERGE_SAT_EN
    do_start(1, 1);
    send_tile(0, 0, 1, 1, 0, 0, '{32'h7fffffff}, 0);
    send_tile(0, 0, 1, 1, 1, 1, '{1}, 0);
    drain('{32'h7fffffff}, 0);
    chk("sat_flag_set", 32'(sat_flag), 1);
    do_start(1, 1);
    chk("sat_flag_clear", 32'(sat_flag), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
